// File: rtl/cluster_pkg.sv
`default_nettype none
//==============================================================================
// Module   : cluster_pkg
// Brief    : Shared widths, noise label, point record and scheduler states.
// Revision : 1.0 - initial release
//==============================================================================
package cluster_pkg;

    localparam int COORD_W_DEFAULT = 8;
    localparam int LABEL_W_DEFAULT = 4;

    localparam logic [LABEL_W_DEFAULT-1:0] NOISE_LABEL = '1;

    typedef struct packed {
        logic [COORD_W_DEFAULT-1:0] x;
        logic [COORD_W_DEFAULT-1:0] y;
        logic [COORD_W_DEFAULT-1:0] z;
        logic                       last;
    } point_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/point_fifo.sv
`default_nettype none
//==============================================================================
// Module   : point_fifo
// Brief    : Synchronous FIFO with full/empty flags; a same-cycle pop never
//            frees room for a push.
// Revision : 1.0 - initial release
//==============================================================================
module point_fifo #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int c_addr_w = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [c_addr_w:0]  r_wr_ptr;
    logic [c_addr_w:0]  r_rd_ptr;
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic               w_wr_en;
    logic               w_rd_en;

    assign empty   = (r_wr_ptr == r_rd_ptr);
    assign full    = (r_wr_ptr[c_addr_w] != r_rd_ptr[c_addr_w]) &&
                     (r_wr_ptr[c_addr_w-1:0] == r_rd_ptr[c_addr_w-1:0]);
    assign rd_data = r_mem[r_rd_ptr[c_addr_w-1:0]];
    assign w_wr_en = push && !full;
    assign w_rd_en = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr_ptr[c_addr_w-1:0]] <= wr_data;
    end

endmodule
`default_nettype wire

// File: rtl/cluster_point_sched.sv
`default_nettype none
//==============================================================================
// Module   : cluster_point_sched
// Brief    : Buffers 3D points and feeds them one at a time to the clustering
//            engine, returning labels with a hung-engine timeout.
//            Define CLUSTER_ECHO_EN to add out_x/out_y/out_z coordinate echo.
// Revision : 1.0 - initial release
//==============================================================================
module cluster_point_sched
    import cluster_pkg::*;
#(
    parameter int COORD_W     = COORD_W_DEFAULT,
    parameter int LABEL_W     = LABEL_W_DEFAULT,
    parameter int FIFO_DEPTH  = 16,
    parameter int ENG_TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic [COORD_W-1:0] z,
    input  logic               valid,
    input  logic               last,
    output logic               eng_start,
    output logic [COORD_W-1:0] eng_x,
    output logic [COORD_W-1:0] eng_y,
    output logic [COORD_W-1:0] eng_z,
    input  logic               eng_done,
    input  logic [LABEL_W-1:0] eng_label,
    output logic [LABEL_W-1:0] label,
    output logic               out_valid,
    output logic               done,
    output logic               overflow,
    output logic               timeout_err
`ifdef CLUSTER_ECHO_EN
    ,
    output logic [COORD_W-1:0] out_x,
    output logic [COORD_W-1:0] out_y,
    output logic [COORD_W-1:0] out_z
`endif
);

    localparam int                  c_pt_w     = 3 * COORD_W + 1;
    localparam int                  c_tmr_w    = $clog2(ENG_TIMEOUT + 1);
    localparam logic [c_tmr_w-1:0]  c_tmr_last = c_tmr_w'(ENG_TIMEOUT - 1);
    localparam logic [LABEL_W-1:0]  c_noise    = {LABEL_W{NOISE_LABEL[0]}};

    sched_state_t        r_state;
    logic [c_tmr_w-1:0]  r_timer;
    logic [COORD_W-1:0]  r_cur_x;
    logic [COORD_W-1:0]  r_cur_y;
    logic [COORD_W-1:0]  r_cur_z;
    logic                r_cur_last;
    logic                r_last_dropped;
    logic                r_eng_start;
    logic [LABEL_W-1:0]  r_label;
    logic                r_out_valid;
    logic                r_done;
    logic                r_overflow;
    logic                r_timeout_err;
    logic                w_full;
    logic                w_empty;
    logic                w_pop;
    logic                w_finish;
    logic [c_pt_w-1:0]   w_rd_data;
`ifdef CLUSTER_ECHO_EN
    logic [COORD_W-1:0]  r_out_x;
    logic [COORD_W-1:0]  r_out_y;
    logic [COORD_W-1:0]  r_out_z;
`endif

    assign w_pop    = (r_state == ST_IDLE) && !w_empty;
    // A real result in the last timeout cycle takes priority over the noise label.
    assign w_finish = eng_done || (r_timer == c_tmr_last);

    point_fifo #(
        .WIDTH (c_pt_w),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (valid),
        .wr_data ({x, y, z, last}),
        .pop     (w_pop),
        .rd_data (w_rd_data),
        .full    (w_full),
        .empty   (w_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_timer        <= '0;
            r_cur_x        <= '0;
            r_cur_y        <= '0;
            r_cur_z        <= '0;
            r_cur_last     <= 1'b0;
            r_last_dropped <= 1'b0;
            r_eng_start    <= 1'b0;
            r_label        <= '0;
            r_out_valid    <= 1'b0;
            r_done         <= 1'b0;
            r_overflow     <= 1'b0;
            r_timeout_err  <= 1'b0;
`ifdef CLUSTER_ECHO_EN
            r_out_x        <= '0;
            r_out_y        <= '0;
            r_out_z        <= '0;
`endif
        end else begin
            r_eng_start <= 1'b0;
            r_out_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        {r_cur_x, r_cur_y, r_cur_z, r_cur_last} <= w_rd_data;
                        r_eng_start <= 1'b1;
                        r_state     <= ST_ISSUE;
                    end else if (r_last_dropped) begin
                        r_last_dropped <= 1'b0;
                        r_done         <= 1'b1;
                        r_state        <= ST_DONE;
                    end
                end
                ST_ISSUE: begin
                    r_timer <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (w_finish) begin
                        r_label     <= eng_done ? eng_label : c_noise;
                        r_out_valid <= 1'b1;
                        if (!eng_done) r_timeout_err <= 1'b1;
`ifdef CLUSTER_ECHO_EN
                        r_out_x     <= r_cur_x;
                        r_out_y     <= r_cur_y;
                        r_out_z     <= r_cur_z;
`endif
                        r_done      <= r_cur_last;
                        r_state     <= r_cur_last ? ST_DONE : ST_IDLE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (valid) begin
                        r_done  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
            // A dropped last point still has to close the frame once the FIFO drains.
            if (valid && w_full) begin
                r_overflow <= 1'b1;
                if (last) r_last_dropped <= 1'b1;
            end
        end
    end

    assign eng_start   = r_eng_start;
    assign eng_x       = r_cur_x;
    assign eng_y       = r_cur_y;
    assign eng_z       = r_cur_z;
    assign label       = r_label;
    assign out_valid   = r_out_valid;
    assign done        = r_done;
    assign overflow    = r_overflow;
    assign timeout_err = r_timeout_err;
`ifdef CLUSTER_ECHO_EN
    assign out_x       = r_out_x;
    assign out_y       = r_out_y;
    assign out_z       = r_out_z;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cluster_point_sched.sv
`default_nettype none
//==============================================================================
// Module   : tb_cluster_point_sched
// Brief    : Scoreboard bench for cluster_point_sched with a behavioural engine.
// Revision : 1.0 - initial release
//==============================================================================
module tb_cluster_point_sched;

    localparam int COORD_W     = 8;
    localparam int LABEL_W     = 4;
    localparam int FIFO_DEPTH  = 16;
    localparam int ENG_TIMEOUT = 255;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [COORD_W-1:0] x = '0, y = '0, z = '0;
    logic               valid = 1'b0, last = 1'b0;
    logic               eng_start;
    logic [COORD_W-1:0] eng_x, eng_y, eng_z;
    logic               eng_done;
    logic [LABEL_W-1:0] eng_label;
    logic [LABEL_W-1:0] label;
    logic               out_valid, done, overflow, timeout_err;
`ifdef CLUSTER_ECHO_EN
    logic [COORD_W-1:0] out_x, out_y, out_z;
`endif

    int                 n_cmp = 0;
    int                 n_bad = 0;
    logic [LABEL_W-1:0] exp_q[$];
    logic [LABEL_W-1:0] exp_lbl;

    bit                 eng_on  = 1'b0;
    int                 eng_lat = 1;
    int                 eng_fix = -1;
    int                 eng_cnt = -1;
    logic [LABEL_W-1:0] eng_pend = '0;

    cluster_point_sched #(
        .COORD_W     (COORD_W),
        .LABEL_W     (LABEL_W),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .ENG_TIMEOUT (ENG_TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .x           (x),
        .y           (y),
        .z           (z),
        .valid       (valid),
        .last        (last),
        .eng_start   (eng_start),
        .eng_x       (eng_x),
        .eng_y       (eng_y),
        .eng_z       (eng_z),
        .eng_done    (eng_done),
        .eng_label   (eng_label),
        .label       (label),
        .out_valid   (out_valid),
        .done        (done),
        .overflow    (overflow),
        .timeout_err (timeout_err)
`ifdef CLUSTER_ECHO_EN
        ,
        .out_x       (out_x),
        .out_y       (out_y),
        .out_z       (out_z)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [LABEL_W-1:0] lbl_of(input logic [7:0] a, input logic [7:0] b,
                                                  input logic [7:0] c);
        logic [7:0] s;
        s = a + b + c;
        return s[3:0] ^ s[7:4];
    endfunction

    // Engine model: answers eng_lat cycles after the start pulse (done lands in
    // the WAIT cycle whose timer value is eng_lat-1).
    initial begin
        eng_done  = 1'b0;
        eng_label = '0;
        forever begin
            @(negedge clk);
            eng_done = 1'b0;
            if (eng_cnt > 0) eng_cnt--;
            else if (eng_cnt == 0) begin
                eng_done  = 1'b1;
                eng_label = eng_pend;
                eng_cnt   = -1;
            end
            if (eng_on && eng_start === 1'b1) begin
                eng_cnt  = eng_lat - 1;
                eng_pend = (eng_fix >= 0) ? 4'(eng_fix) : lbl_of(eng_x, eng_y, eng_z);
            end
        end
    end

    task automatic send(input logic [7:0] px, input logic [7:0] py, input logic [7:0] pz,
                        input logic pl);
        @(negedge clk);
        x = px; y = py; z = pz; last = pl; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0; last = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (eng_start !== 1'b0) begin n_bad++; $display("FAIL reset_eng_start: got %b want 0", eng_start); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL reset_timeout_err: got %b want 0", timeout_err); end
        n_cmp++; if (label !== 4'd0) begin n_bad++; $display("FAIL reset_label: got %0d want 0", label); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        int starts = 0;
        bit got = 1'b0;
        eng_on = 1'b1; eng_lat = 5; eng_fix = 3;
        exp_q.push_back(4'd3);
        send(8'd10, 8'd10, 8'd10, 1'b1);
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (eng_start === 1'b1) begin
                starts++;
                n_cmp++; if (eng_x !== 8'd10) begin n_bad++; $display("FAIL single_eng_x: got %0d want 10", eng_x); end
            end
            if (out_valid === 1'b1) begin
                got = 1'b1;
                exp_lbl = exp_q.pop_front();
                n_cmp++; if (label !== exp_lbl) begin n_bad++; $display("FAIL single_label: got %0d want %0d", label, exp_lbl); end
                n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL single_done: got %b want 1", done); end
`ifdef CLUSTER_ECHO_EN
                n_cmp++; if (out_x !== 8'd10) begin n_bad++; $display("FAIL single_out_x: got %0d want 10", out_x); end
`endif
            end
        end
        n_cmp++; if (!got) begin n_bad++; $display("FAIL single_no_label: got 0 labels want 1"); exp_q.delete(); end
        n_cmp++; if (starts != 1) begin n_bad++; $display("FAIL single_start_count: got %0d want 1", starts); end
        n_cmp++; if (overflow !== 1'b0 || timeout_err !== 1'b0) begin
            n_bad++; $display("FAIL single_flags: got ovf=%b tmo=%b want 0 0", overflow, timeout_err);
        end
    endtask

    task automatic test_frame_restart();
        bit got = 1'b0;
        eng_lat = 4; eng_fix = -1;
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL restart_pre_done: got %b want 1", done); end
        exp_q.push_back(lbl_of(8'd50, 8'd50, 8'd50));
        send(8'd50, 8'd50, 8'd50, 1'b1);
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL restart_done_drop: got %b want 0", done); end
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                got = 1'b1;
                exp_lbl = exp_q.pop_front();
                n_cmp++; if (label !== exp_lbl) begin n_bad++; $display("FAIL restart_label: got %0d want %0d", label, exp_lbl); end
                n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL restart_done: got %b want 1", done); end
            end
        end
        n_cmp++; if (!got) begin n_bad++; $display("FAIL restart_no_label: got 0 labels want 1"); exp_q.delete(); end
    endtask

    task automatic test_race();
        bit got = 1'b0;
        eng_lat = ENG_TIMEOUT; eng_fix = 5;
        exp_q.push_back(4'd5);
        send(8'd7, 8'd7, 8'd7, 1'b1);
        for (int i = 0; i < 320 && !got; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                got = 1'b1;
                exp_lbl = exp_q.pop_front();
                n_cmp++; if (label !== exp_lbl) begin n_bad++; $display("FAIL race_label: got %0d want %0d", label, exp_lbl); end
                n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL race_timeout_err: got %b want 0", timeout_err); end
            end
        end
        n_cmp++; if (!got) begin n_bad++; $display("FAIL race_no_label: got 0 labels want 1"); exp_q.delete(); end
    endtask

    task automatic test_timeout();
        int got = 0;
        int t0  = 0;
        eng_on = 1'b0;
        exp_q.push_back(4'd15);
        exp_q.push_back(4'd15);
        send(8'd1, 8'd2, 8'd3, 1'b0);
        send(8'd4, 8'd5, 8'd6, 1'b1);
        for (int i = 0; i < 800 && got < 2; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                exp_lbl = exp_q.pop_front();
                n_cmp++; if (label !== exp_lbl) begin n_bad++; $display("FAIL timeout_label: got %0d want %0d", label, exp_lbl); end
                if (got == 0) t0 = i;
                else begin
                    n_cmp++; if (i - t0 != ENG_TIMEOUT + 2) begin
                        n_bad++; $display("FAIL timeout_spacing: got %0d want %0d", i - t0, ENG_TIMEOUT + 2);
                    end
                end
                got++;
            end
        end
        n_cmp++; if (got != 2) begin n_bad++; $display("FAIL timeout_count: got %0d want 2", got); exp_q.delete(); end
        n_cmp++; if (timeout_err !== 1'b1) begin n_bad++; $display("FAIL timeout_err_flag: got %b want 1", timeout_err); end
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL timeout_done: got %b want 1", done); end
    endtask

    task automatic test_async_reset();
        bit seen = 1'b0;
        bit got  = 1'b0;
        int stale = 0;
        eng_on = 1'b1; eng_lat = 20; eng_fix = -1;
        send(8'd9, 8'd9, 8'd9, 1'b1);
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (eng_start === 1'b1) seen = 1'b1;
        end
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL areset_no_start: got 0 want 1"); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (eng_start !== 1'b0) begin n_bad++; $display("FAIL areset_eng_start: got %b want 0", eng_start); end
        n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL areset_timeout_err: got %b want 0", timeout_err); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL areset_done: got %b want 0", done); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) stale++;
        end
        n_cmp++; if (stale != 0) begin n_bad++; $display("FAIL areset_stale_out: got %0d want 0", stale); end
        eng_lat = 3;
        exp_q.push_back(lbl_of(8'd33, 8'd44, 8'd55));
        send(8'd33, 8'd44, 8'd55, 1'b1);
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                got = 1'b1;
                exp_lbl = exp_q.pop_front();
                n_cmp++; if (label !== exp_lbl) begin n_bad++; $display("FAIL areset_fresh_label: got %0d want %0d", label, exp_lbl); end
                n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL areset_fresh_done: got %b want 1", done); end
            end
        end
        n_cmp++; if (!got) begin n_bad++; $display("FAIL areset_fresh_none: got 0 labels want 1"); exp_q.delete(); end
    endtask

    task automatic test_back_to_back();
        bit acc[50];
        int cnt = 0, next_pop = 0, n_exp = 0, got = 0;
        bit saw_done = 1'b0;
        eng_lat = 6; eng_fix = -1;
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL b2b_pre_overflow: got %b want 0", overflow); end
        // Occupancy model: point k arrives at edge 2k; a pop happens when idle and
        // non-empty, and the next pop is possible eng_lat+2 edges later.
        for (int e = 0; e < 1000; e++) begin
            bit w, p, a;
            w = (e % 2 == 0) && (e / 2 < 50);
            p = (e >= next_pop) && (cnt > 0);
            a = w && (cnt < FIFO_DEPTH);
            if (w) acc[e / 2] = a;
            cnt = cnt + int'(a) - int'(p);
            if (p) next_pop = e + eng_lat + 2;
        end
        foreach (acc[k]) if (acc[k]) n_exp++;
        fork
            begin
                for (int k = 0; k < 50; k++) begin
                    logic [7:0] px, py, pz;
                    px = 8'(k * 3 + 1); py = 8'(k * 5); pz = 8'(255 - k);
                    if (acc[k]) exp_q.push_back(lbl_of(px, py, pz));
                    send(px, py, pz, k == 49);
                end
            end
            begin
                for (int i = 0; i < 1500 && got < n_exp; i++) begin
                    @(negedge clk);
                    if (out_valid === 1'b1) begin
                        if (exp_q.size() == 0) begin
                            n_cmp++; n_bad++; $display("FAIL b2b_extra_label: got %0d want none", label);
                        end else begin
                            exp_lbl = exp_q.pop_front();
                            n_cmp++; if (label !== exp_lbl) begin n_bad++; $display("FAIL b2b_label: got %0d want %0d", label, exp_lbl); end
                        end
                        got++;
                    end
                end
            end
        join
        n_cmp++; if (got != n_exp) begin n_bad++; $display("FAIL b2b_count: got %0d want %0d", got, n_exp); exp_q.delete(); end
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL b2b_overflow: got %b want 1", overflow); end
        for (int i = 0; i < 10 && !saw_done; i++) begin
            if (done === 1'b1) saw_done = 1'b1;
            else @(negedge clk);
        end
        n_cmp++; if (!saw_done) begin n_bad++; $display("FAIL b2b_done: got 0 want 1"); end
    endtask

    task automatic test_last_dropped();
        int got = 0;
        bit saw_done = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ldrop_pre_overflow: got %b want 0", overflow); end
        eng_lat = 40; eng_fix = -1;
        // Point 0 is popped at once, 1..16 fill the FIFO, 17 (last) is dropped.
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            x = 8'(k + 100); y = 8'(k * 7); z = 8'(k * 11);
            last = (k == 17); valid = 1'b1;
            if (k < 17) exp_q.push_back(lbl_of(x, y, z));
        end
        @(negedge clk);
        valid = 1'b0; last = 1'b0;
        for (int i = 0; i < 1200 && got < 17; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                exp_lbl = exp_q.pop_front();
                n_cmp++; if (label !== exp_lbl) begin n_bad++; $display("FAIL ldrop_label: got %0d want %0d", label, exp_lbl); end
                got++;
            end
        end
        n_cmp++; if (got != 17) begin n_bad++; $display("FAIL ldrop_count: got %0d want 17", got); exp_q.delete(); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL ldrop_early_done: got %b want 0", done); end
        for (int i = 0; i < 5 && !saw_done; i++) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
        end
        n_cmp++; if (!saw_done) begin n_bad++; $display("FAIL ldrop_done: got 0 want 1"); end
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ldrop_overflow: got %b want 1", overflow); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_frame_restart();
        test_race();
        test_timeout();
        test_async_reset();
        test_back_to_back();
        test_last_dropped();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
